// File: rtl/ov7670_pkg.sv
// Shared constants and types for the dual-camera OV7670 frame-buffer write path.
package ov7670_pkg;

    localparam int c_img_cols    = 160;
    localparam int c_img_rows    = 120;
    localparam int c_nb_img_pxls = $clog2(c_img_cols * c_img_rows);
    localparam int c_nb_buf      = 12;
    localparam int c_nb_cam_id   = 1;
    localparam int c_fifo_depth  = 4;
    localparam int c_nb_entry    = c_nb_img_pxls + c_nb_buf;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPT    = 2'd2
    } cam_state_t;

endpackage

// File: rtl/arb_fifo.sv
// Small synchronous FIFO; a push while full is ignored, a pop while empty is ignored.
module arb_fifo #(
    parameter int c_depth = 4,
    parameter int c_width = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [c_width-1:0] din,
    output logic [c_width-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int c_aw = $clog2(c_depth);

    logic [c_width-1:0] mem_q [c_depth];
    logic [c_aw:0]      wr_q;
    logic [c_aw:0]      rd_q;
    logic               do_push;
    logic               do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[c_aw] != rd_q[c_aw]) && (wr_q[c_aw-1:0] == rd_q[c_aw-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (c_aw+1)'(1);
            if (do_pop)  rd_q <= rd_q + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[c_aw-1:0]] <= din;
    end

endmodule

// File: rtl/ov7670_wr_arbiter.sv
// Round-robin merge of two frame-gated camera write streams onto one frame-buffer port.
// Optional macro ARB_OVF_CNT_EN adds saturating per-camera drop counters ovf_cnt0/ovf_cnt1.
module ov7670_wr_arbiter
    import ov7670_pkg::*;
#(
    parameter int c_depth = c_fifo_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cam0_en,
    input  logic                     cam0_vsync,
    input  logic                     cam0_we,
    input  logic [c_nb_img_pxls-1:0] cam0_addr,
    input  logic [c_nb_buf-1:0]      cam0_dout,
    input  logic                     cam1_en,
    input  logic                     cam1_vsync,
    input  logic                     cam1_we,
    input  logic [c_nb_img_pxls-1:0] cam1_addr,
    input  logic [c_nb_buf-1:0]      cam1_dout,
    input  logic                     ovf_clr,
    output logic                     mem_we,
    output logic [c_nb_img_pxls:0]   mem_addr,
    output logic [c_nb_buf-1:0]      mem_din,
    output logic [1:0]               capturing,
    output logic [1:0]               frame_done,
    output logic [1:0]               ovf
`ifdef ARB_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_cnt0,
    output logic [7:0]               ovf_cnt1
`endif
);

    logic [1:0]            en;
    logic [1:0]            vs;
    logic [1:0]            we;
    logic [1:0]            vs_prev_q;
    logic [1:0]            vs_rise;
    logic [1:0]            acc;
    logic [1:0]            drop;
    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            pop;
    logic [1:0]            done_q;
    logic [1:0]            ovf_q;
    logic                  last_q;
    logic                  mem_we_q;
    logic [c_nb_img_pxls:0] mem_addr_q;
    logic [c_nb_buf-1:0]   mem_din_q;
    cam_state_t            st_q [2];
    cam_state_t            st_d [2];
    logic [c_nb_entry-1:0] fin  [2];
    logic [c_nb_entry-1:0] fout [2];

    assign en     = {cam1_en, cam0_en};
    assign vs     = {cam1_vsync, cam0_vsync};
    assign we     = {cam1_we, cam0_we};
    assign fin[0] = {cam0_addr, cam0_dout};
    assign fin[1] = {cam1_addr, cam1_dout};

    // A write counts when the camera is (or is just becoming) in CAPT after this cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            vs_rise[i] = vs[i] && !vs_prev_q[i];
            st_d[i]    = st_q[i];
            case (st_q[i])
                IDLE:    if (en[i]) st_d[i] = WAIT_VS;
                WAIT_VS: begin
                    if (!en[i])          st_d[i] = IDLE;
                    else if (vs_rise[i]) st_d[i] = CAPT;
                end
                CAPT:    if (vs_rise[i] && !en[i]) st_d[i] = IDLE;
                default: st_d[i] = IDLE;
            endcase
            acc[i]  = we[i] && (st_d[i] == CAPT);
            drop[i] = acc[i] && full[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) st_q[i] <= IDLE;
            vs_prev_q <= '0;
            done_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                done_q[i] <= (st_q[i] == CAPT) && vs_rise[i];
            end
            vs_prev_q <= vs;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        arb_fifo #(
            .c_depth (c_depth),
            .c_width (c_nb_entry)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (acc[g]),
            .pop   (pop[g]),
            .din   (fin[g]),
            .dout  (fout[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // last_q remembers the camera granted most recently; the other one wins a tie.
    always_comb begin
        pop = 2'b00;
        if (!empty[0] && !empty[1]) pop = last_q ? 2'b01 : 2'b10;
        else if (!empty[0])         pop = 2'b01;
        else if (!empty[1])         pop = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ovf_q      <= '0;
        end else begin
            mem_we_q <= |pop;
            if (|pop) begin
                last_q     <= pop[1];
                mem_addr_q <= {pop[1], pop[1] ? fout[1][c_nb_entry-1:c_nb_buf]
                                              : fout[0][c_nb_entry-1:c_nb_buf]};
                mem_din_q  <= pop[1] ? fout[1][c_nb_buf-1:0] : fout[0][c_nb_buf-1:0];
            end
            for (int i = 0; i < 2; i++) begin
                if (drop[i])      ovf_q[i] <= 1'b1;
                else if (ovf_clr) ovf_q[i] <= 1'b0;
            end
        end
    end

`ifdef ARB_OVF_CNT_EN
    logic [7:0] cnt_q [2];

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ovf_clr)                          cnt_q[i] <= drop[i] ? 8'd1 : 8'd0;
                else if (drop[i] && cnt_q[i] != 8'hff) cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    assign ovf_cnt0 = cnt_q[0];
    assign ovf_cnt1 = cnt_q[1];
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign frame_done = done_q;
    assign ovf        = ovf_q;
    assign capturing  = {st_q[1] == CAPT, st_q[0] == CAPT};

endmodule

// File: tb/tb_ov7670_wr_arbiter.sv
// Randomized bench for ov7670_wr_arbiter: queue-based reference model plus decoupled output monitor.
module tb_ov7670_wr_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        cam0_en, cam0_vsync, cam0_we;
    logic [14:0] cam0_addr;
    logic [11:0] cam0_dout;
    logic        cam1_en, cam1_vsync, cam1_we;
    logic [14:0] cam1_addr;
    logic [11:0] cam1_dout;
    logic        ovf_clr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [11:0] mem_din;
    logic [1:0]  capturing;
    logic [1:0]  frame_done;
    logic [1:0]  ovf;
`ifdef ARB_OVF_CNT_EN
    logic [7:0]  ovf_cnt0;
    logic [7:0]  ovf_cnt1;
`endif

    ov7670_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cam0_en    (cam0_en),
        .cam0_vsync (cam0_vsync),
        .cam0_we    (cam0_we),
        .cam0_addr  (cam0_addr),
        .cam0_dout  (cam0_dout),
        .cam1_en    (cam1_en),
        .cam1_vsync (cam1_vsync),
        .cam1_we    (cam1_we),
        .cam1_addr  (cam1_addr),
        .cam1_dout  (cam1_dout),
        .ovf_clr    (ovf_clr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .capturing  (capturing),
        .frame_done (frame_done),
        .ovf        (ovf)
`ifdef ARB_OVF_CNT_EN
        ,
        .ovf_cnt0   (ovf_cnt0),
        .ovf_cnt1   (ovf_cnt1)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Camera states: 0 idle, 1 waiting for vsync, 2 capturing.
    logic [27:0] exp_q[$];
    logic [26:0] mq0[$];
    logic [26:0] mq1[$];
    int          m_st [2];
    logic [1:0]  m_vs_prev, m_done, m_ovf, m_cap;
    logic        m_last, m_we;
    logic [15:0] m_addr;
    logic [11:0] m_din;
    int          m_cnt [2];
    bit          started = 0;

    logic [1:0]  en_v, vs_v, we_v, acc, drop;
    logic        rise;
    int          nst, n0, n1, g;
    logic [26:0] ent;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_st[0] = 0; m_st[1] = 0;
            m_vs_prev = 0; m_done = 0; m_ovf = 0; m_last = 1; m_we = 0;
            m_addr = 0; m_din = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            en_v = {cam1_en, cam0_en};
            vs_v = {cam1_vsync, cam0_vsync};
            we_v = {cam1_we, cam0_we};
            for (int i = 0; i < 2; i++) begin
                rise      = vs_v[i] && !m_vs_prev[i];
                m_done[i] = (m_st[i] == 2) && rise;
                if (m_st[i] == 0)      nst = en_v[i] ? 1 : 0;
                else if (m_st[i] == 1) nst = !en_v[i] ? 0 : (rise ? 2 : 1);
                else                   nst = (rise && !en_v[i]) ? 0 : 2;
                acc[i]  = we_v[i] && (nst == 2);
                m_st[i] = nst;
            end
            m_vs_prev = vs_v;

            n0 = mq0.size();
            n1 = mq1.size();
            g  = -1;
            if (n0 > 0 && n1 > 0) g = m_last ? 0 : 1;
            else if (n0 > 0)      g = 0;
            else if (n1 > 0)      g = 1;
            m_we = (g >= 0);
            if (g >= 0) begin
                ent = (g == 0) ? mq0.pop_front() : mq1.pop_front();
                exp_q.push_back({g[0], ent});
                m_last = g[0];
                m_addr = {g[0], ent[26:12]};
                m_din  = ent[11:0];
            end

            drop = 2'b00;
            if (acc[0]) begin
                if (n0 >= DEPTH) drop[0] = 1'b1;
                else mq0.push_back({cam0_addr, cam0_dout});
            end
            if (acc[1]) begin
                if (n1 >= DEPTH) drop[1] = 1'b1;
                else mq1.push_back({cam1_addr, cam1_dout});
            end
            for (int i = 0; i < 2; i++) begin
                if (drop[i])      m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
                if (ovf_clr)                     m_cnt[i] = drop[i] ? 1 : 0;
                else if (drop[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_cap = {m_st[1] == 2, m_st[0] == 2};
    end

    // ---------------- monitor / scoreboard ----------------
    logic [27:0] got_e;

    always @(negedge clk) begin
        if (started) begin
            check("capturing", 32'(capturing), 32'(m_cap));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef ARB_OVF_CNT_EN
            check("ovf_cnt0", 32'(ovf_cnt0), 32'(m_cnt[0]));
            check("ovf_cnt1", 32'(ovf_cnt1), 32'(m_cnt[1]));
`endif
            check("mem_we", 32'(mem_we), 32'(m_we));
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL spurious_write: got addr %0h with no write expected", mem_addr);
                end else begin
                    got_e = exp_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(got_e[27:12]));
                    check("mem_din", 32'(mem_din), 32'(got_e[11:0]));
                end
            end else begin
                check("mem_addr_hold", 32'(mem_addr), 32'(m_addr));
                check("mem_din_hold", 32'(mem_din), 32'(m_din));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_random(input int n, input int p_we, input int p_en, input int p_vs, input int p_clr);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 99) < p_en) cam0_en = ~cam0_en;
            if ($urandom_range(0, 99) < p_en) cam1_en = ~cam1_en;
            if ($urandom_range(0, 99) < p_vs) cam0_vsync = ~cam0_vsync;
            if ($urandom_range(0, 99) < p_vs) cam1_vsync = ~cam1_vsync;
            cam0_we   = ($urandom_range(0, 99) < p_we);
            cam1_we   = ($urandom_range(0, 99) < p_we);
            cam0_addr = 15'($urandom);
            cam1_addr = 15'($urandom);
            cam0_dout = 12'($urandom);
            cam1_dout = 12'($urandom);
            ovf_clr   = ($urandom_range(0, 99) < p_clr);
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        cam0_en = 0; cam0_vsync = 0; cam0_we = 0; cam0_addr = 0; cam0_dout = 0;
        cam1_en = 0; cam1_vsync = 0; cam1_we = 0; cam1_addr = 0; cam1_dout = 0;
        ovf_clr = 0;
        do_reset(3);

        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_din", 32'(mem_din), 32'd0);
        check("reset_capturing", 32'(capturing), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        // Single write from camera 0 after entering a frame.
        cam0_en = 1'b1;
        tick();
        tick();
        cam0_vsync = 1'b1;
        tick();
        cam0_we = 1'b1; cam0_addr = 15'h0005; cam0_dout = 12'hABC;
        tick();
        cam0_we = 1'b0;
        tick();
        check("first_mem_we", 32'(mem_we), 32'd1);
        check("first_mem_addr", 32'(mem_addr), 32'h00005);
        check("first_mem_din", 32'(mem_din), 32'hABC);
        check("first_capturing", 32'(capturing), 32'b01);
        tick();

        run_random(600, 15, 1, 3, 1);
        cam0_en = 1'b1;
        cam1_en = 1'b1;
        run_random(400, 90, 0, 1, 0);
        run_random(300, 60, 0, 2, 0);
        do_reset(2);
        run_random(600, 50, 2, 4, 5);
        run_random(200, 95, 0, 2, 10);
        do_reset(1);
        run_random(300, 30, 1, 3, 2);

        cam0_we = 1'b0;
        cam1_we = 1'b0;
        ovf_clr = 1'b0;
        repeat (30) tick();
        check("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
